rvfi_shadow_monitor: RTL

Retirement-stream consistency monitor that sits directly downstream of the Ibex formal wrapper's RVFI outputs. It keeps a shadow copy of the integer register file built from retired writebacks. Every retirement is checked for order continuity, source-operand consistency, x0 integrity and PC continuity. Results are sticky error flags plus first-failure capture, for use as formal assert targets or in simulation benches.

---
 rtl/rvfi_shadow_monitor.sv | 128 ++++++++++++
 1 files changed

// File: rtl/rvfi_shadow_monitor.sv
// Retirement-stream consistency monitor for RVFI: shadows the integer register file
// from retired writebacks and flags order, operand, x0 and PC inconsistencies.
module rvfi_shadow_monitor #(
    parameter bit          CheckPc = 1'b1,
    parameter int unsigned CntW    = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            rvfi_valid,
    input  logic [63:0]     rvfi_order,
    input  logic [31:0]     rvfi_insn,
    input  logic            rvfi_trap,
    input  logic            rvfi_intr,
    input  logic [4:0]      rvfi_rs1_addr,
    input  logic [4:0]      rvfi_rs2_addr,
    input  logic [31:0]     rvfi_rs1_rdata,
    input  logic [31:0]     rvfi_rs2_rdata,
    input  logic [4:0]      rvfi_rd_addr,
    input  logic [31:0]     rvfi_rd_wdata,
    input  logic [31:0]     rvfi_pc_rdata,
    input  logic [31:0]     rvfi_pc_wdata,
    output logic            err_order_o,
    output logic            err_rs1_o,
    output logic            err_rs2_o,
    output logic            err_x0_o,
    output logic            err_pc_o,
    output logic            err_o,
    output logic [63:0]     first_err_order_o,
    output logic [31:0]     first_err_insn_o,
    output logic [CntW-1:0] retired_o
);

    logic [63:0]     exp_order_q;
    logic [31:0]     shadow_q [32];
    logic [31:0]     known_q;
    logic [31:0]     last_pc_q;
    logic            have_pc_q;
    logic            err_order_q, err_rs1_q, err_rs2_q, err_x0_q, err_pc_q, err_q;
    logic [63:0]     first_order_q;
    logic [31:0]     first_insn_q;
    logic [CntW-1:0] retired_q;

    logic [31:0] rs1_shadow, rs2_shadow;
    logic        fail_order, fail_rs1, fail_rs2, fail_x0, fail_pc, fail_any;
    logic        shadow_wr;

    // Operand checks read the shadow before this retirement's own write lands.
    always_comb begin
        rs1_shadow = shadow_q[rvfi_rs1_addr];
        rs2_shadow = shadow_q[rvfi_rs2_addr];
        fail_order = 1'b0;
        fail_rs1   = 1'b0;
        fail_rs2   = 1'b0;
        fail_x0    = 1'b0;
        fail_pc    = 1'b0;
        if (rvfi_valid) begin
            fail_order = (rvfi_order != exp_order_q);
            if (rvfi_rs1_addr == 5'd0) begin
                fail_rs1 = (rvfi_rs1_rdata != 32'd0);
            end else begin
                fail_rs1 = known_q[rvfi_rs1_addr] && (rvfi_rs1_rdata != rs1_shadow);
            end
            if (rvfi_rs2_addr == 5'd0) begin
                fail_rs2 = (rvfi_rs2_rdata != 32'd0);
            end else begin
                fail_rs2 = known_q[rvfi_rs2_addr] && (rvfi_rs2_rdata != rs2_shadow);
            end
            fail_x0 = (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0);
            fail_pc = CheckPc && have_pc_q && !rvfi_intr && (rvfi_pc_rdata != last_pc_q);
        end
        fail_any  = fail_order | fail_rs1 | fail_rs2 | fail_x0 | fail_pc;
        shadow_wr = rvfi_valid && !rvfi_trap && (rvfi_rd_addr != 5'd0);
    end

    always_ff @(posedge clk_i) begin
        if (shadow_wr) begin
            shadow_q[rvfi_rd_addr] <= rvfi_rd_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            exp_order_q   <= 64'd0;
            known_q       <= 32'd0;
            last_pc_q     <= 32'd0;
            have_pc_q     <= 1'b0;
            err_order_q   <= 1'b0;
            err_rs1_q     <= 1'b0;
            err_rs2_q     <= 1'b0;
            err_x0_q      <= 1'b0;
            err_pc_q      <= 1'b0;
            err_q         <= 1'b0;
            first_order_q <= 64'd0;
            first_insn_q  <= 32'd0;
            retired_q     <= '0;
        end else if (rvfi_valid) begin
            // Resync to the observed order so a single gap does not cascade.
            exp_order_q <= rvfi_order + 64'd1;
            last_pc_q   <= rvfi_pc_wdata;
            have_pc_q   <= 1'b1;
            retired_q   <= retired_q + CntW'(1);
            if (shadow_wr) begin
                known_q[rvfi_rd_addr] <= 1'b1;
            end
            err_order_q <= err_order_q | fail_order;
            err_rs1_q   <= err_rs1_q | fail_rs1;
            err_rs2_q   <= err_rs2_q | fail_rs2;
            err_x0_q    <= err_x0_q | fail_x0;
            err_pc_q    <= err_pc_q | fail_pc;
            err_q       <= err_q | fail_any;
            if (fail_any && !err_q) begin
                first_order_q <= rvfi_order;
                first_insn_q  <= rvfi_insn;
            end
        end
    end

    assign err_order_o       = err_order_q;
    assign err_rs1_o         = err_rs1_q;
    assign err_rs2_o         = err_rs2_q;
    assign err_x0_o          = err_x0_q;
    assign err_pc_o          = CheckPc ? err_pc_q : 1'b0;
    assign err_o             = err_q;
    assign first_err_order_o = first_order_q;
    assign first_err_insn_o  = first_insn_q;
    assign retired_o         = retired_q;

endmodule
